// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags, carry-chained ADC/SBC and a shift-add
// unsigned multiplier; one-cycle ops complete in IDLE, MUL runs WIDTH cycles.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_SBC = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplr;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic             cin;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [PW-1:0]    acc_step;

  // Single-cycle datapath; carry-in is the flag registered before this accept.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    cin     = (op == OP_ADC || op == OP_SBC) ? flag_c : 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        ext     = {1'b0, a} + {1'b0, b} + W1'(cin);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow.
        ext     = {1'b0, a} - {1'b0, b} - W1'(cin);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc + (mplr[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand <= PW'(a);
              mplr  <= b;
              acc   <= '0;
              cnt   <= CW'(WIDTH);
              ready <= 1'b0;
              state <= MUL_RUN;
            end else begin
              result <= alu_res;
              flag_n <= alu_res[MSB];
              flag_z <= (alu_res == '0);
              flag_c <= alu_c;
              flag_v <= alu_v;
              done   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          acc   <= acc_step;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= acc_step[WIDTH-1:0];
            flag_n <= acc_step[MSB];
            flag_z <= (acc_step[WIDTH-1:0] == '0);
            flag_c <= (acc_step[PW-1:WIDTH] != '0);
            flag_v <= 1'b0;
            done   <= 1'b1;
            ready  <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table, back-to-back ops,
// multiplier timing and reset abort, with a queue of expected results.
module tb_alu_seq;

  localparam int unsigned W = 8;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int tests;
  int fails;
  exp_t sb[$];
  vec_t vecs[10];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .ready(ready), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [2:0] o, logic [W-1:0] x, logic [W-1:0] y,
                              logic [W-1:0] r, logic [3:0] f);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.nzcv = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r; e.nzcv = f;
    sb.push_back(e);
  endtask

  // Called at a sampling point where done must be high: pop and compare.
  task automatic expect_done(input string name);
    exp_t e;
    chk({name, "_done"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_result"}, 32'(result), 32'(e.res));
      chk({name, "_nzcv"}, 32'({flag_n, flag_z, flag_c, flag_v}), 32'(e.nzcv));
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    start = s; op = o; a = x; b = y;
  endtask

  // One-cycle op: done visible exactly one cycle after the accept edge.
  task automatic run_single(input string name, input vec_t v);
    drive(1'b1, v.op, v.a, v.b);
    push(v.res, v.nzcv);
    @(negedge clk);
    drive(1'b0, 3'd0, '0, '0);
    expect_done(name);
    chk({name, "_ready"}, 32'(ready), 32'd1);
    @(negedge clk);
    chk({name, "_done_low"}, 32'(done), 32'd0);
  endtask

  // MUL with a start pulse during busy cycle k+3 that must be ignored.
  task automatic run_mul(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input logic [3:0] f);
    drive(1'b1, 3'd7, x, y);
    push(r, f);
    for (int c = 1; c <= int'(W); c++) begin
      @(negedge clk);
      if (c == 3) drive(1'b1, 3'd0, 8'h11, 8'h22);
      else        drive(1'b0, 3'd0, '0, '0);
      chk($sformatf("%s_busy_ready_c%0d", name, c), 32'(ready), 32'd0);
      chk($sformatf("%s_busy_done_c%0d", name, c), 32'(done), 32'd0);
    end
    @(negedge clk);
    expect_done(name);
    chk({name, "_ready_end"}, 32'(ready), 32'd1);
    @(negedge clk);
    chk({name, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    drive(1'b1, 3'd0, 8'h01, 8'h01);
    vecs[0] = mk(3'd0, 8'h7F, 8'h01, 8'h80, 4'b1001);
    vecs[1] = mk(3'd0, 8'hFF, 8'h01, 8'h00, 4'b0110);
    vecs[2] = mk(3'd5, 8'h00, 8'h00, 8'h01, 4'b0000);
    vecs[3] = mk(3'd1, 8'h00, 8'h01, 8'hFF, 4'b1010);
    vecs[4] = mk(3'd6, 8'h05, 8'h02, 8'h02, 4'b0000);
    vecs[5] = mk(3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001);
    vecs[6] = mk(3'd6, 8'h00, 8'h00, 8'h00, 4'b0100);
    vecs[7] = mk(3'd0, 8'h80, 8'h80, 8'h00, 4'b0111);
    vecs[8] = mk(3'd6, 8'h00, 8'h00, 8'hFF, 4'b1010);
    vecs[9] = mk(3'd5, 8'h7F, 8'h00, 8'h80, 4'b1001);

    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    rst = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_single($sformatf("vec%0d", i), vecs[i]);

    // start held high: one accept per cycle
    drive(1'b1, 3'd2, 8'hF0, 8'h3C);
    push(8'h30, 4'b0000);
    @(negedge clk);
    expect_done("b2b_and");
    op = 3'd3;
    push(8'hFC, 4'b1000);
    @(negedge clk);
    expect_done("b2b_or");
    op = 3'd4;
    push(8'hCC, 4'b1000);
    @(negedge clk);
    expect_done("b2b_xor");
    drive(1'b0, 3'd0, '0, '0);
    @(negedge clk);
    chk("b2b_done_low", 32'(done), 32'd0);

    run_mul("mul_10x10", 8'h10, 8'h10, 8'h00, 4'b0110);
    run_mul("mul_0dx0b", 8'h0D, 8'h0B, 8'h8F, 4'b1000);
    run_mul("mul_by0", 8'hFF, 8'h00, 8'h00, 4'b0100);
    run_mul("mul_ffxff", 8'hFF, 8'hFF, 8'h01, 4'b0010);

    // Reset during MUL: no done, outputs back to reset values
    run_single("pre_abort", mk(3'd0, 8'h40, 8'h41, 8'h81, 4'b1001));
    drive(1'b1, 3'd7, 8'h0D, 8'h0B);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive(1'b0, 3'd0, '0, '0);
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({flag_n, flag_z, flag_c, flag_v}), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done_c%0d", c), 32'(done), 32'd0);
    end
    run_single("post_abort_add", mk(3'd0, 8'h02, 8'h03, 8'h05, 4'b0000));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
